// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: fetch FSM encoding, NOP, reset vector, opcodes.
package rv32_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t S_BOOT  = 2'd0;
   localparam fetch_state_t S_FETCH = 2'd1;
   localparam fetch_state_t S_FULL  = 2'd2;
   localparam fetch_state_t S_DRAIN = 2'd3;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small fetched-instruction buffer with push/pop/flush; flush dominates both.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_push_data,
   output logic [WIDTH-1:0] o_head_data,
   output logic             o_full,
   output logic             o_almost_full,
   output logic             o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_full        = (r_count == CW'(DEPTH));
   assign o_almost_full = (r_count == CW'(DEPTH - 1));
   assign o_empty       = (r_count == '0);
   assign o_head_data   = r_mem[r_rd_ptr];

   assign w_pop  = i_pop && !i_flush && !o_empty;
   assign w_push = i_push && !i_flush && (!o_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: issues word-aligned imem requests, buffers returns, handles redirects.
module fetch_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   fetch_stage_if.master        imem,
   output logic [31:0]          instr_de,
   output logic [31:0]          pc_de,
   output logic [31:0]          pc_4_de,
   output logic                 valid_de
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  w_fetch_pc_next;
   logic [31:0]  r_pending_pc;
   logic [31:0]  w_pending_pc_next;

   logic         w_req;
   logic         w_ack;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_almost_full;
   logic         w_empty;
   logic         w_full_after;
   logic [31:0]  w_redirect_target;
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head_entry;

   assign w_req             = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign w_ack             = w_req && imem.imem_ack;
   assign w_redirect_target = redirect_pc & ~32'd3;

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_fetch_pc;

   // Redirect flushes the buffer and suppresses both pop and push in that edge.
   assign w_push = (r_state == S_FETCH) && w_ack && !redirect;
   assign w_pop  = valid_de && !stall && !redirect;
   assign w_full_after = (w_full && !w_pop) || (w_almost_full && w_push && !w_pop);

   assign w_push_entry.instr = imem.imem_rdata;
   assign w_push_entry.pc    = r_fetch_pc;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .i_flush       (redirect),
      .i_push        (w_push),
      .i_pop         (w_pop),
      .i_push_data   (w_push_entry),
      .o_head_data   (w_head_entry),
      .o_full        (w_full),
      .o_almost_full (w_almost_full),
      .o_empty       (w_empty)
   );

   assign valid_de = !w_empty;
   assign instr_de = w_empty ? NOP_INSTR  : w_head_entry.instr;
   assign pc_de    = w_empty ? r_fetch_pc : w_head_entry.pc;
   assign pc_4_de  = pc_plus4(pc_de);

   always_comb begin
      w_state_next      = r_state;
      w_fetch_pc_next   = r_fetch_pc;
      w_pending_pc_next = r_pending_pc;
      case (r_state)
         S_BOOT:  w_state_next = S_FETCH;
         S_FETCH: begin
            if (w_push)       w_fetch_pc_next = pc_plus4(r_fetch_pc);
            if (w_full_after) w_state_next    = S_FULL;
         end
         S_FULL:  if (w_pop) w_state_next = S_FETCH;
         S_DRAIN: begin
            if (w_ack) begin
               w_fetch_pc_next = r_pending_pc;
               w_state_next    = S_FETCH;
            end
         end
         default: w_state_next = S_BOOT;
      endcase
      // An unacked request must complete before the new target goes out.
      if (redirect) begin
         if (w_req && !imem.imem_ack) begin
            w_pending_pc_next = w_redirect_target;
            w_state_next      = S_DRAIN;
         end else begin
            w_fetch_pc_next = w_redirect_target;
            w_state_next    = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_BOOT;
         r_fetch_pc   <= RESET_PC;
         r_pending_pc <= '0;
      end else begin
         r_state      <= w_state_next;
         r_fetch_pc   <= w_fetch_pc_next;
         r_pending_pc <= w_pending_pc_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected {instr,pc} queued on accepted acks, checked on consume.
module tb_fetch_stage;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr_de;
   logic [31:0] pc_de;
   logic [31:0] pc_4_de;
   logic        valid_de;

   fetch_stage_if imem ();

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem),
      .instr_de    (instr_de),
      .pc_de       (pc_de),
      .pc_4_de     (pc_4_de),
      .valid_de    (valid_de)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_fetch_pc;
   logic [31:0] m_pending_pc;
   logic        m_discard;
   logic [31:0] held;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0000_5A00;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample at negedge, drive inputs, update the model for the coming edge.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic ack_en);
      logic [63:0] e;
      logic        req;
      logic        ack;
      logic [31:0] addr;
      @(negedge clk);
      check_val("valid_de", 32'(valid_de), 32'(sb_q.size() != 0));
      if (!valid_de) begin
         check_val("nop_instr", instr_de, NOP_INSTR);
         check_val("pc_empty", pc_de, m_fetch_pc);
      end
      req  = imem.imem_req;
      addr = imem.imem_addr;
      if (req) check_val("imem_addr", addr, m_fetch_pc);
      ack = ack_en && req;
      stall = st;
      redirect = rd;
      redirect_pc = rpc;
      imem.imem_ack = ack;
      imem.imem_rdata = mem_word(addr);
      if (valid_de && !st && !rd && sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_val("instr_de", instr_de, e[63:32]);
         check_val("pc_de", pc_de, e[31:0]);
         check_val("pc_4_de", pc_4_de, e[31:0] + 32'd4);
         $display("consume pc=%h instr=%h", pc_de, instr_de);
      end
      if (rd) sb_q.delete();
      if (ack) begin
         if (m_discard) begin
            m_discard = 1'b0;
            if (!rd) m_fetch_pc = m_pending_pc;
         end else if (!rd) begin
            sb_q.push_back({mem_word(addr), addr});
            m_fetch_pc = addr + 32'd4;
         end
      end
      if (rd) begin
         if (req && !ack) begin
            m_pending_pc = {rpc[31:2], 2'b00};
            m_discard = 1'b1;
         end else begin
            m_fetch_pc = {rpc[31:2], 2'b00};
         end
      end
   endtask

   task automatic reset_outputs(input string tag);
      check_val({tag, "_req"}, 32'(imem.imem_req), 32'd0);
      check_val({tag, "_valid"}, 32'(valid_de), 32'd0);
      check_val({tag, "_instr"}, instr_de, NOP_INSTR);
      check_val({tag, "_pc"}, pc_de, 32'h0);
      check_val({tag, "_pc4"}, pc_4_de, 32'h4);
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_fetch_pc = 32'h0;
      m_pending_pc = 32'h0;
      m_discard = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      imem.imem_ack = 1'b0;
      imem.imem_rdata = 32'h0;
      model_reset();
      @(negedge clk);
      #1 reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      #1 check_val("boot_req", 32'(imem.imem_req), 32'd0);

      // Zero-wait stream; first fetch must be out right after the boot cycle
      cycle(0, 0, 0, 1);
      check_val("fetch_req", 32'(imem.imem_req), 32'd1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

      // Backpressure: four stall cycles fill the buffer and idle the bus
      cycle(1, 0, 0, 1);
      held = instr_de;
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      check_val("full_req", 32'(imem.imem_req), 32'd0);
      check_val("stall_hold", instr_de, held);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

      // Drain: request at 0x10 acked late, redirect to 0x200 in its second cycle
      cycle(0, 1, 32'h10, 1);
      cycle(0, 0, 0, 0);
      check_val("drain_old_addr", imem.imem_addr, 32'h10);
      cycle(0, 1, 32'h200, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      check_val("drain_new_addr", imem.imem_addr, 32'h200);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

      // Redirect under stall with a full buffer; low target bits dropped
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
      cycle(1, 1, 32'h0000_0103, 1);
      cycle(0, 0, 0, 1);
      check_val("redir_req", 32'(imem.imem_req), 32'd1);
      check_val("redir_addr", imem.imem_addr, 32'h100);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

      // Address wrap at the top of the space
      cycle(0, 1, 32'hFFFF_FFFC, 1);
      cycle(0, 0, 0, 1);
      check_val("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 1);
      check_val("wrap_pc4", pc_4_de, 32'h0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

      // Random mix of stalls, wait states and redirects
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
               $urandom(), 1'($urandom_range(0, 2) != 0));
      end

      // Async reset mid-request with an ack pulsed while reset is high
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check_val("pre_rst_req", 32'(imem.imem_req), 32'd1);
      #2;
      rst = 1'b1;
      imem.imem_ack = 1'b1;
      imem.imem_rdata = 32'hCAFE_F00D;
      #1 reset_outputs("arst");
      @(posedge clk);
      #1 check_val("arst_nopush", 32'(valid_de), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      imem.imem_ack = 1'b0;
      model_reset();
      #1 check_val("arst_boot_req", 32'(imem.imem_req), 32'd0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, fetched-instruction buffer entries (fixed at 2 in this release).
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have stall  input  1  decode stage not consuming this cycle (from hazard manager).
REQ-006 SHALL have redirect  input  1  taken branch/jump; flush and refetch.
REQ-007 SHALL have redirect_pc  input  32  target address for redirect.
REQ-008 SHALL have imem_req  output  1  instruction memory request.
REQ-009 SHALL have imem_addr  output  32  request address, word-aligned.
REQ-010 SHALL have imem_ack  input  1  request accepted, imem_rdata valid this cycle.
REQ-011 SHALL have imem_rdata  input  32  fetched instruction.
REQ-012 SHALL have instr_de  output  32  instruction presented to decode.
REQ-013 SHALL have pc_de  output  32  PC of instr_de.
REQ-014 SHALL have pc_4_de  output  32  pc_de + 4, for JAL/JALR write-back.
REQ-015 SHALL have valid_de  output  1  instr_de holds a real fetched instruction.

Function
REQ-016 SHALL implement FSM states S_BOOT, S_FETCH, S_FULL, S_DRAIN.
REQ-017 S_BOOT: imem_req=0 for exactly one cycle after rst release, then S_FETCH.
REQ-018 S_FETCH: imem_req=1, imem_addr=fetch_pc; go to S_FULL when FIFO full after this cycle's push/pop.
REQ-019 Once imem_req is asserted, imem_req and imem_addr SHALL stay stable until imem_ack, except across reset.
REQ-020 On imem_ack without redirect: push {imem_rdata, imem_addr} into FIFO; fetch_pc += 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 S_FULL: imem_req=0; return to S_FETCH the cycle after a pop.
REQ-022 FIFO head SHALL drive instr_de/pc_de/pc_4_de with valid_de=1 when non-empty; pop when !stall && valid_de.
REQ-023 Empty FIFO SHALL drive instr_de=32'h0000_0013 (NOP), valid_de=0, pc_de=fetch_pc.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; a push into an empty FIFO is visible on the following cycle, not combinationally.
REQ-025 Redirect SHALL flush FIFO in the same edge (valid_de=0 next cycle), with priority over stall and push.
REQ-026 Redirect with no unacked request: fetch_pc <= {redirect_pc[31:2],2'b00}; next state S_FETCH.
REQ-027 Redirect while imem_req=1 and !imem_ack: latch target into pending_pc, go to S_DRAIN.
REQ-028 S_DRAIN: hold old request until imem_ack, discard its data, then fetch_pc <= pending_pc and go to S_FETCH.
REQ-029 Redirect in the same cycle as imem_ack SHALL discard the acked data and go directly per REQ-026.
REQ-030 Redirect during S_DRAIN SHALL overwrite pending_pc; last redirect wins.
REQ-031 redirect_pc[1:0] SHALL be ignored (forced to zero).

Reset
REQ-032 On rst: state=S_BOOT, fetch_pc=RESET_PC, FIFO empty, pending_pc=0.
REQ-033 On rst: imem_req=0, valid_de=0, instr_de=NOP, pc_de=RESET_PC, pc_4_de=RESET_PC+4.
REQ-034 On rst mid-request: drop the request immediately; ignore any ack received while rst is high.

Structure
REQ-035 Shared package rv32_pkg SHALL hold NOP_INSTR (32'h0000_0013), RESET_PC default, FSM state typedef, opcode constants shared with decode and hazard manager.
REQ-036 The FIFO SHALL be a sub-module fetch_fifo (2-entry, 64-bit {instr,pc}, push/pop/flush, full/empty).
REQ-037 Implementation SHALL fit in 120-400 RTL lines.

Verification
REQ-038 Reset and stream: RESET_PC=0, zero-wait ack, no stall -> imem_addr 0,4,8; valid_de pc_de 0,4,8 each cycle from cycle 3.
REQ-039 Backpressure: stall held 4 cycles -> FIFO fills with 2 entries, imem_req=0, instr_de stable; release -> in-order drain, no loss or duplication.
REQ-040 Drain: ack delayed 3 cycles on addr 0x10, redirect to 0x200 in cycle 1 -> 0x10 data discarded, next imem_addr=0x200, valid_de=0 until 0x200 returns.
REQ-041 Redirect with stall: redirect=1, stall=1, FIFO full, redirect_pc=0x0000_0103 -> FIFO flushed, next fetch 0x100.
REQ-042 Wrap: redirect to 0xFFFF_FFFC -> following fetch at 0x0000_0000; pc_4_de=0 for the first.
REQ-043 Async reset asserted mid-request with ack pulsed during reset -> outputs per REQ-033 within the same cycle, no FIFO push.
